// File: rtl/dmem_run_ctrl_if.sv
// Host-side bus of the run controller: run start, memory request/grant and the
// registered read-data return.
interface dmem_run_ctrl_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              host_go;
    logic              host_req;
    logic              host_we;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic              host_gnt;
    logic [DATA_W-1:0] host_rdata;
    logic              host_rvalid;

    modport master (
        output host_go, host_req, host_we, host_addr, host_wdata,
        input  host_gnt, host_rdata, host_rvalid
    );

    modport slave (
        input  host_go, host_req, host_we, host_addr, host_wdata,
        output host_gnt, host_rdata, host_rvalid
    );
endinterface

// File: rtl/dmem_run_ctrl.sv
// Run controller for the 8-bit core: sequences host preload, core execution and
// completion/timeout, and arbitrates the single data-memory port between host and core.
module dmem_run_ctrl #(
    parameter int          ADDR_W      = 8,
    parameter int          DATA_W      = 8,
    parameter logic [7:0]  DONE_PC     = 8'hFF,
    parameter int          TIMEOUT_CYC = 4096,
    parameter int          CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    dmem_run_ctrl_if.slave    host,
    input  logic [7:0]        core_pc,
    input  logic              core_mem_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic [DATA_W-1:0] core_rdata,
    output logic              core_run,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic [CNT_W-1:0]  cycle_count
);

    typedef enum logic [1:0] {IDLE, RUN, DONE, TOUT} state_t;

    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_t           state;
    logic             host_side;
    logic             host_read;
    logic [CNT_W-1:0] cnt_inc;

    // The host owns the memory port whenever the core is not running.
    always_comb begin
        host_side = (state != RUN);
        host_read = host_side && host.host_req && !host.host_we;
        cnt_inc   = (cycle_count == '1) ? cycle_count : cycle_count + CNT_W'(1);
        if (host_side) begin
            mem_we    = host.host_we & host.host_req;
            mem_addr  = host.host_addr;
            mem_wdata = host.host_wdata;
        end else begin
            mem_we    = core_mem_we;
            mem_addr  = core_addr;
            mem_wdata = core_wdata;
        end
    end

    assign host.host_gnt = host_side & host.host_req;
    assign core_rdata    = mem_rdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state            <= IDLE;
            core_run         <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
            timeout          <= 1'b0;
            cycle_count      <= '0;
            host.host_rdata  <= '0;
            host.host_rvalid <= 1'b0;
        end else begin
            host.host_rvalid <= host_read;
            if (host_read) begin
                host.host_rdata <= mem_rdata;
            end
            case (state)
                RUN: begin
                    // The completing cycle is still counted; completion beats timeout.
                    cycle_count <= cnt_inc;
                    if (core_pc == DONE_PC) begin
                        state    <= DONE;
                        done     <= 1'b1;
                        core_run <= 1'b0;
                        busy     <= 1'b0;
                    end else if (cycle_count == TIMEOUT_LAST) begin
                        state    <= TOUT;
                        timeout  <= 1'b1;
                        core_run <= 1'b0;
                        busy     <= 1'b0;
                    end
                end
                default: begin
                    if (host.host_go) begin
                        state       <= RUN;
                        done        <= 1'b0;
                        timeout     <= 1'b0;
                        cycle_count <= '0;
                        core_run    <= 1'b1;
                        busy        <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule
